// File: rtl/booth_multiplier_ieee754.sv
// booth_multiplier_ieee754: iterative fp32 multiplier, one significand bit per cycle.
// Shift-add over 24-bit significands, then normalise and round-to-nearest-even.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   multiplicand_i, multiplier_i : fp32 operands, latched on an accepted start
//   start_flag : start request, honoured only when idle
//   busy_o     : operation in progress
//   valid_o    : one-cycle pulse, result_o/error_o valid
//   error_o    : NaN result or overflow
//   result_o   : fp32 product, held until the next result is produced
module booth_multiplier_ieee754 #(
    parameter int width = 23,
    parameter int EXP_W = 8,
    parameter int BIAS  = 127
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [EXP_W+width:0]     multiplicand_i,
    input  logic [EXP_W+width:0]     multiplier_i,
    input  logic                     start_flag,
    output logic                     busy_o,
    output logic                     valid_o,
    output logic                     error_o,
    output logic [EXP_W+width:0]     result_o
);

    localparam int MW = width + 1;
    localparam int PW = 2 * MW;
    localparam int OW = EXP_W + width;
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_NORM,
        S_SPEC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [PW-1:0]   p_q, p_d;
    logic [OW-1:0]   a_q, a_d;
    logic [OW-1:0]   b_q, b_d;
    logic            sign_q, sign_d;
    logic [OW:0]     res_q, res_d;
    logic            err_q, err_d;

    // Operand classification on the raw inputs (denormals count as zero).
    logic [EXP_W-1:0] ea_in, eb_in;
    logic             special_in;

    assign ea_in = multiplicand_i[width +: EXP_W];
    assign eb_in = multiplier_i[width +: EXP_W];
    assign special_in = (ea_in == '0) || (ea_in == EMAX) ||
                        (eb_in == '0) || (eb_in == EMAX);

    // Classification of latched (already flushed) operands.
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;

    assign a_zero = (a_q[width +: EXP_W] == '0);
    assign b_zero = (b_q[width +: EXP_W] == '0);
    assign a_inf  = (a_q[width +: EXP_W] == EMAX) && (a_q[width-1:0] == '0);
    assign b_inf  = (b_q[width +: EXP_W] == EMAX) && (b_q[width-1:0] == '0);
    assign a_nan  = (a_q[width +: EXP_W] == EMAX) && (a_q[width-1:0] != '0);
    assign b_nan  = (b_q[width +: EXP_W] == EMAX) && (b_q[width-1:0] != '0);

    // Upper half of the product register accumulates the multiplicand
    // whenever the multiplier bit shifted into position 0 is set.
    logic [MW:0] mul_sum;

    assign mul_sum = {1'b0, p_q[PW-1:MW]} +
                     (p_q[0] ? {2'b01, a_q[width-1:0]} : '0);

    // Normalisation and round-to-nearest-even of the finished product.
    logic             nrm;
    logic [width-1:0] mant;
    logic             g_bit, s_bit, rnd;
    logic [width:0]   rnd_sum;
    logic             carry;
    logic [EW-1:0]    exp_r;
    logic             ovf, unf;

    assign nrm   = p_q[PW-1];
    assign mant  = nrm ? p_q[PW-2 -: width] : p_q[PW-3 -: width];
    assign g_bit = nrm ? p_q[MW-1] : p_q[MW-2];
    assign s_bit = nrm ? (|p_q[MW-2:0]) : (|p_q[MW-3:0]);
    assign rnd   = g_bit & (s_bit | mant[0]);

    // A carry out of the fraction leaves it all-zero: value is 2.0, so
    // only the exponent needs the extra increment.
    assign rnd_sum = {1'b0, mant} + {{width{1'b0}}, rnd};
    assign carry   = rnd_sum[width];

    // Two extra bits: top bit acts as sign for underflow detection.
    assign exp_r = EW'(a_q[width +: EXP_W]) + EW'(b_q[width +: EXP_W])
                 - EW'(BIAS) + EW'(nrm) + EW'(carry);
    assign ovf = !exp_r[EW-1] && (exp_r >= EW'(EMAX));
    assign unf = exp_r[EW-1] || (exp_r == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_flag) begin
                    a_d = (ea_in == '0) ? '0 : multiplicand_i[OW-1:0];
                    b_d = (eb_in == '0) ? '0 : multiplier_i[OW-1:0];
                    sign_d = multiplicand_i[OW] ^ multiplier_i[OW];
                    p_d = {{MW{1'b0}}, 1'b1, multiplier_i[width-1:0]};
                    cnt_d = 5'(width);
                    state_d = special_in ? S_SPEC : S_MUL;
                end
            end
            S_MUL: begin
                p_d   = {mul_sum, p_q[MW-1:1]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == '0) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                state_d = S_DONE;
                if (ovf) begin
                    res_d = {sign_q, EMAX, {width{1'b0}}};
                    err_d = 1'b1;
                end else if (unf) begin
                    res_d = {sign_q, {OW{1'b0}}};
                    err_d = 1'b0;
                end else begin
                    res_d = {sign_q, exp_r[EXP_W-1:0], rnd_sum[width-1:0]};
                    err_d = 1'b0;
                end
            end
            S_SPEC: begin
                state_d = S_DONE;
                if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
                    res_d = {1'b0, EMAX, 1'b1, {(width-1){1'b0}}};
                    err_d = 1'b1;
                end else if (a_inf || b_inf) begin
                    res_d = {sign_q, EMAX, {width{1'b0}}};
                    err_d = 1'b0;
                end else begin
                    res_d = {sign_q, {OW{1'b0}}};
                    err_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign busy_o   = (state_q == S_MUL) || (state_q == S_NORM) ||
                      (state_q == S_SPEC);
    assign valid_o  = (state_q == S_DONE);
    assign error_o  = err_q;
    assign result_o = res_q;

endmodule

// File: tb/tb_booth_multiplier_ieee754.sv
// tb_booth_multiplier_ieee754: vector table, random ops vs. integer
// reference model, and hand sequences for reset / ignored starts.
`timescale 1ns/1ps
module tb_booth_multiplier_ieee754;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    logic        start_flag;
    logic        busy_o;
    logic        valid_o;
    logic        error_o;
    logic [31:0] result_o;

    booth_multiplier_ieee754 dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .start_flag     (start_flag),
        .busy_o         (busy_o),
        .valid_o        (valid_o),
        .error_o        (error_o),
        .result_o       (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vt[13];

    int n_cmp = 0;
    int n_bad = 0;

    int last_busy_cnt;
    logic last_busy_at_valid;
    logic last_valid_after;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact integer product, rounded by remainder comparison.
    function automatic logic [32:0] model(input logic [31:0] a,
                                          input logic [31:0] b);
        logic sgn;
        int ea, eb, e, sh;
        logic [22:0] fa, fb;
        longint unsigned ma, mb, prod, mant, rem, half;
        logic za, zb, ia, ib, na, nb;
        sgn = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        if (na || nb || (za && ib) || (ia && zb))
            return {1'b1, 32'h7FC0_0000};
        if (ia || ib)
            return {1'b0, sgn, 8'hFF, 23'h0};
        if (za || zb)
            return {1'b0, sgn, 31'h0};
        ma = 64'(fa) + 64'h80_0000;
        mb = 64'(fb) + 64'h80_0000;
        prod = ma * mb;
        sh = (prod >= (64'd1 << 47)) ? 24 : 23;
        mant = prod >> sh;
        rem = prod & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && mant[0]))
            mant = mant + 64'd1;
        e = ea + eb - 127 + (sh == 24 ? 1 : 0);
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e = e + 1;
        end
        if (e >= 255)
            return {1'b1, sgn, 8'hFF, 23'h0};
        if (e <= 0)
            return {1'b0, sgn, 31'h0};
        return {1'b0, sgn, 8'(e), mant[22:0]};
    endfunction

    // Called just after a negedge; returns after the cycle following valid.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic err,
                         output int lat);
        multiplicand_i = a;
        multiplier_i   = b;
        start_flag     = 1'b1;
        @(negedge clk_i);
        start_flag     = 1'b0;
        multiplicand_i = $urandom;
        multiplier_i   = $urandom;
        lat = 1;
        last_busy_cnt = 0;
        while (!valid_o && lat < 40) begin
            if (busy_o) last_busy_cnt++;
            @(negedge clk_i);
            lat++;
        end
        if (!valid_o) lat = -1;
        res = result_o;
        err = error_o;
        last_busy_at_valid = busy_o;
        @(negedge clk_i);
        last_valid_after = valid_o;
    endtask

    function automatic logic [31:0] rnd_fp();
        int r;
        logic [7:0] e;
        r = int'($urandom_range(0, 15));
        if (r == 0)
            e = 8'h00;
        else if (r == 1)
            e = 8'hFF;
        else if (r == 2)
            e = 8'($urandom_range(1, 20));
        else if (r == 3)
            e = 8'($urandom_range(230, 254));
        else
            e = 8'($urandom_range(64, 190));
        if (r == 1 && $urandom_range(0, 1) == 0)
            return {1'($urandom), e, 23'h0};
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    logic [31:0] res;
    logic        err;
    int          lat;
    logic [32:0] exp_m;
    logic [31:0] ra, rb;
    int          cyc;
    int          nval;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 26};
        vt[1]  = '{32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000, 1'b0, 26};
        vt[2]  = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0, 26};
        vt[3]  = '{32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 1'b0, 26};
        vt[4]  = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b1, 2};
        vt[5]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 26};
        vt[6]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 26};
        vt[7]  = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 2};
        vt[8]  = '{32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000, 1'b0, 2};
        vt[9]  = '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 2};
        vt[10] = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0, 2};
        vt[11] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 26};
        vt[12] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0, 26};

        rst_i = 1'b0;
        start_flag = 1'b0;
        multiplicand_i = '0;
        multiplier_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset error", 32'(error_o), 32'd0);
        check("reset result", result_o, 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_op(vt[i].a, vt[i].b, res, err, lat);
            check($sformatf("vec%0d result", i), res, vt[i].res);
            check($sformatf("vec%0d error", i), 32'(err), 32'(vt[i].err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
            check($sformatf("vec%0d pulse", i), 32'(last_valid_after), 32'd0);
        end

        do_op(32'h4000_0000, 32'h4040_0000, res, err, lat);
        check("busy cycles", 32'(last_busy_cnt), 32'd25);
        check("busy at valid", 32'(last_busy_at_valid), 32'd0);

        // Start during busy must be ignored.
        multiplicand_i = 32'h4000_0000;
        multiplier_i   = 32'h4040_0000;
        start_flag     = 1'b1;
        @(negedge clk_i);
        start_flag     = 1'b0;
        repeat (4) @(negedge clk_i);
        multiplicand_i = 32'h3FC0_0000;
        multiplier_i   = 32'h3FC0_0000;
        start_flag     = 1'b1;
        @(negedge clk_i);
        start_flag     = 1'b0;
        cyc = 6;
        while (!valid_o && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
        end
        check("busy-start latency", 32'(cyc), 32'd26);
        check("busy-start result", result_o, 32'h40C0_0000);
        nval = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (valid_o) nval++;
        end
        check("busy-start no extra valid", 32'(nval), 32'd0);
        do_op(32'h3FC0_0000, 32'hBFC0_0000, res, err, lat);
        check("after ignored start", res, 32'hC010_0000);

        // Start in DONE must be ignored.
        multiplicand_i = 32'h0000_0000;
        multiplier_i   = 32'h7F80_0000;
        start_flag     = 1'b1;
        @(negedge clk_i);
        start_flag     = 1'b0;
        @(negedge clk_i);
        check("done cycle valid", 32'(valid_o), 32'd1);
        multiplicand_i = 32'h3F80_0000;
        multiplier_i   = 32'h3F80_0000;
        start_flag     = 1'b1;
        @(negedge clk_i);
        start_flag     = 1'b0;
        check("start in done ignored", 32'(busy_o), 32'd0);

        // Reset in the middle of a multiply.
        do_op(32'h7F00_0000, 32'h7F00_0000, res, err, lat);
        multiplicand_i = 32'h4000_0000;
        multiplier_i   = 32'h4040_0000;
        start_flag     = 1'b1;
        @(negedge clk_i);
        start_flag     = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        check("midreset busy", 32'(busy_o), 32'd0);
        check("midreset valid", 32'(valid_o), 32'd0);
        check("midreset error", 32'(error_o), 32'd0);
        check("midreset result", result_o, 32'd0);
        nval = 0;
        repeat (35) begin
            @(negedge clk_i);
            if (valid_o) nval++;
        end
        check("midreset no valid", 32'(nval), 32'd0);

        for (int i = 0; i < 150; i++) begin
            ra = rnd_fp();
            rb = rnd_fp();
            exp_m = model(ra, rb);
            do_op(ra, rb, res, err, lat);
            check($sformatf("rand%0d %h*%h result", i, ra, rb), res, exp_m[31:0]);
            check($sformatf("rand%0d error", i), 32'(err), 32'(exp_m[32]));
            check($sformatf("rand%0d latency", i), 32'(lat),
                  (ra[30:23] == 8'h00 || ra[30:23] == 8'hFF ||
                   rb[30:23] == 8'h00 || rb[30:23] == 8'hFF) ? 32'd2 : 32'd26);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
